// File: rtl/sdm_pkg.sv
// Shared definitions for the sigma-delta demodulator: CIC order, the FSM state
// type and the internal CIC width derived from the decimation ratio.
package sdm_pkg;

  localparam int CIC_ORDER      = 3;
  localparam int WARMUP_OUTPUTS = 3;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Bit growth of a 3rd-order CIC is 3*log2(R), plus sign and headroom.
  function automatic int cic_width(input int decim_log2);
    return CIC_ORDER * decim_log2 + 2;
  endfunction

endpackage

// File: rtl/sdm_demodulator_if.sv
// Sample-in / PCM-out bus of the demodulator.
// Handshake: valid_in qualifies din for exactly one cycle and is always accepted
// (no backpressure); valid_out is a one-cycle pulse qualifying a new dout word.
interface sdm_demodulator_if #(
  parameter int dac_bw = 16
);

  logic                     valid_in;
  logic                     din;
  logic                     valid_out;
  logic signed [dac_bw-1:0] dout;

  modport master (output valid_in, output din, input valid_out, input dout);
  modport slave  (input valid_in, input din, output valid_out, output dout);

endinterface

// File: rtl/sdm_cic_stage.sv
// One integrator/comb pair of the CIC decimator; integrator and comb delay are
// independently enable-gated W-bit registers using modulo-2^W arithmetic.
module sdm_cic_stage #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_int_en,
  input  logic [W-1:0] i_int_in,
  output logic [W-1:0] o_int_sum,
  input  logic         i_comb_en,
  input  logic [W-1:0] i_comb_in,
  output logic [W-1:0] o_comb_diff
);

  logic [W-1:0] r_int;
  logic [W-1:0] r_dly;

  // The integrator sum already includes the current input so the cascade
  // settles within the cycle in which a sample is accepted.
  assign o_int_sum   = r_int + i_int_in;
  assign o_comb_diff = i_comb_in - r_dly;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_int <= '0;
      r_dly <= '0;
    end else begin
      if (i_int_en)  r_int <= o_int_sum;
      if (i_comb_en) r_dly <= i_comb_in;
    end
  end

endmodule

// File: rtl/sdm_demodulator.sv
// Sinc3 CIC decimator turning a 1-bit sigma-delta stream into signed PCM.
// decim_log2 must be at least 1 so the comb pipeline is idle before each tick.
module sdm_demodulator
  import sdm_pkg::*;
#(
  parameter int dac_bw     = 16,
  parameter int decim_log2 = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  sdm_demodulator_if.slave    bus,
  output state_t              o_state
);

  localparam int W     = cic_width(decim_log2);
  localparam int SHIFT = W - 1 - dac_bw;
  localparam logic signed [W-1:0] SAT_MAX = W'((1 << (dac_bw - 1)) - 1);
  localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

  logic [decim_log2-1:0] r_cnt;
  logic [W-1:0]          r_latch;
  logic [W-1:0]          r_comb_res;
  logic                  r_comb_go;
  logic                  r_res_v;
  logic [dac_bw-1:0]     r_dout;
  logic                  r_valid_out;
  logic [1:0]            r_warm_cnt;
  state_t                r_state;

  logic                  w_accept;
  logic                  w_tick;
  logic [W-1:0]          w_x;
  logic signed [W-1:0]   w_shifted;
  logic [dac_bw-1:0]     w_scaled;

  assign w_accept = bus.valid_in;
  assign w_tick   = w_accept && (r_cnt == '1);
  // din=0 maps to +1 and din=1 to -1, matching the modulator feedback.
  assign w_x      = bus.din ? {W{1'b1}} : W'(1);

  for (genvar i = 0; i < CIC_ORDER; i++) begin : g_stage
    logic [W-1:0] w_int_in;
    logic [W-1:0] w_int_sum;
    logic [W-1:0] w_comb_in;
    logic [W-1:0] w_comb_diff;

    if (i == 0) begin : g_first
      assign w_int_in  = w_x;
      assign w_comb_in = r_latch;
    end else begin : g_next
      assign w_int_in  = g_stage[i-1].w_int_sum;
      assign w_comb_in = g_stage[i-1].w_comb_diff;
    end

    sdm_cic_stage #(.W(W)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_int_en   (w_accept),
      .i_int_in   (w_int_in),
      .o_int_sum  (w_int_sum),
      .i_comb_en  (r_comb_go),
      .i_comb_in  (w_comb_in),
      .o_comb_diff(w_comb_diff)
    );
  end

  assign w_shifted = $signed(r_comb_res) >>> SHIFT;

  always_comb begin
    w_scaled = w_shifted[dac_bw-1:0];
    if (w_shifted > SAT_MAX)      w_scaled = SAT_MAX[dac_bw-1:0];
    else if (w_shifted < SAT_MIN) w_scaled = SAT_MIN[dac_bw-1:0];
  end

  // Pipeline: tick edge latches the integrator, next edge runs the combs,
  // the edge after that publishes the scaled word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_latch     <= '0;
      r_comb_res  <= '0;
      r_comb_go   <= 1'b0;
      r_res_v     <= 1'b0;
      r_dout      <= '0;
      r_valid_out <= 1'b0;
      r_warm_cnt  <= '0;
      r_state     <= WARMUP;
    end else begin
      r_valid_out <= 1'b0;
      r_comb_go   <= w_tick;
      r_res_v     <= r_comb_go;
      if (w_accept)  r_cnt      <= r_cnt + 1'b1;
      if (w_tick)    r_latch    <= g_stage[CIC_ORDER-1].w_int_sum;
      if (r_comb_go) r_comb_res <= g_stage[CIC_ORDER-1].w_comb_diff;
      if (r_res_v) begin
        r_dout <= w_scaled;
        case (r_state)
          WARMUP: begin
            if (r_warm_cnt == 2'(WARMUP_OUTPUTS - 1)) r_state <= RUN;
            else                                       r_warm_cnt <= r_warm_cnt + 1'b1;
          end
          RUN:     r_valid_out <= 1'b1;
          default: r_state <= WARMUP;
        endcase
      end
    end
  end

  assign bus.valid_out = r_valid_out;
  assign bus.dout      = r_dout;
  assign o_state       = r_state;

endmodule

// File: tb/tb_sdm_demodulator.sv
// Bench for sdm_demodulator: reference is a direct sinc3 convolution over the
// accepted sample history, decimated, shifted and saturated.
module tb_sdm_demodulator;
  import sdm_pkg::*;

  localparam int DAC_BW = 16;
  localparam int DL     = 6;
  localparam int R      = 1 << DL;
  localparam int W      = 3 * DL + 2;
  localparam int SHIFT  = W - 1 - DAC_BW;
  localparam int HLEN   = 3 * R - 2;
  localparam longint PMAX = (64'sd1 <<< (DAC_BW - 1)) - 1;
  localparam longint PMIN = -(64'sd1 <<< (DAC_BW - 1));

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t st;

  sdm_demodulator_if #(.dac_bw(DAC_BW)) bus ();

  sdm_demodulator #(.dac_bw(DAC_BW), .decim_log2(DL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .o_state(st)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int hold_err = 0;
  int n_out = 0;
  int h[HLEN];
  int hist[$];
  logic [DAC_BW-1:0] exp_q[$];
  logic [DAC_BW-1:0] got_q[$];
  int exp_cyc_q[$];
  int got_cyc_q[$];
  logic [DAC_BW-1:0] model_dout;
  logic [DAC_BW-1:0] prev_dout = '0;
  state_t prev_st = WARMUP;

  // ---------------- clock / cycle count / output monitor ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) begin
      got_q.push_back(bus.dout);
      got_cyc_q.push_back(cyc);
    end else if (prev_st == RUN && st == RUN && bus.dout !== prev_dout) begin
      hold_err++;
    end
    prev_dout = bus.dout;
    prev_st   = st;
  end

  // ---------------- reference model ----------------
  function automatic void build_kernel();
    for (int j = 0; j < HLEN; j++) h[j] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++) h[a+b+c]++;
  endfunction

  function automatic void model_reset();
    hist.delete();
    n_out = 0;
    model_dout = '0;
  endfunction

  function automatic void model_accept(input bit d, input int edge_no);
    longint y;
    int n;
    hist.push_back(d ? -1 : 1);
    n = hist.size();
    if (n % R == 0) begin
      y = 0;
      for (int j = 0; j < HLEN && j < n; j++) y += longint'(h[j]) * longint'(hist[n-1-j]);
      y = y >>> SHIFT;
      if (y > PMAX) y = PMAX;
      else if (y < PMIN) y = PMIN;
      model_dout = y[DAC_BW-1:0];
      n_out++;
      if (n_out > WARMUP_OUTPUTS) begin
        exp_q.push_back(model_dout);
        exp_cyc_q.push_back(edge_no + 2);
      end
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input bit d, input bit v);
    bus.din = d;
    bus.valid_in = v;
    if (v && rst_n) model_accept(d, cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 1'b0);
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    exp_cyc_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    bus.din = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    model_reset();
    clear_q();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // valid_in high while in reset must not be accepted
    rst_n = 1'b0;
    bus.valid_in = 1'b1;
    bus.din = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    tests_run++;
    if (bus.dout !== '0) begin tests_failed++; $display("FAIL reset_dout: got %0d, expected 0", bus.dout); end
    tests_run++;
    if (bus.valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, expected 0", bus.valid_out); end
    tests_run++;
    if (st !== WARMUP) begin tests_failed++; $display("FAIL reset_state: got %0d, expected WARMUP", st); end
    rst_n = 1'b1;
    model_reset();
    clear_q();
  endtask

  task automatic test_const(input bit d, input int nframes, input logic [DAC_BW-1:0] want, input string name);
    do_reset(1);
    for (int k = 0; k < nframes * R; k++) send(d, 1'b1);
    idle(4);
    tests_run++;
    if (got_q.size() !== nframes - WARMUP_OUTPUTS) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d pulses, expected %0d", name, got_q.size(), nframes - WARMUP_OUTPUTS);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== want || got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        tests_failed++;
        $display("FAIL %s_out%0d: got %0d @%0d, expected %0d @%0d", name, i, $signed(got_q[i]), got_cyc_q[i], $signed(want), exp_cyc_q[i]);
      end
    end
  endtask

  task automatic test_alternating();
    logic [DAC_BW-1:0] first_run[$];
    do_reset(1);
    for (int k = 0; k < 6 * R; k++) send(k[0], 1'b1);
    idle(4);
    first_run = got_q;
    tests_run++;
    if (got_q.size() !== exp_q.size() || got_q.size() !== 3) begin
      tests_failed++;
      $display("FAIL alt_count: got %0d pulses, expected 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== '0 || got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        tests_failed++;
        $display("FAIL alt_out%0d: got %0d @%0d, expected 0 @%0d", i, $signed(got_q[i]), got_cyc_q[i], exp_cyc_q[i]);
      end
    end
    do_reset(1);
    for (int k = 0; k < 6 * R; k++) begin
      while ($urandom_range(1, 0) == 1) send(1'b1, 1'b0);
      send(k[0], 1'b1);
    end
    idle(4);
    tests_run++;
    if (got_q.size() !== first_run.size()) begin
      tests_failed++;
      $display("FAIL alt_gap_count: got %0d pulses, expected %0d", got_q.size(), first_run.size());
    end
    for (int i = 0; i < got_q.size() && i < first_run.size() && i < exp_cyc_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== first_run[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        tests_failed++;
        $display("FAIL alt_gap_out%0d: got %0d @%0d, expected %0d @%0d", i, $signed(got_q[i]), got_cyc_q[i], $signed(first_run[i]), exp_cyc_q[i]);
      end
    end
  endtask

  task automatic test_random_gaps();
    do_reset(1);
    for (int k = 0; k < 8 * R; k++) begin
      while ($urandom_range(1, 0) == 1) send(1'($urandom), 1'b0);
      send(1'($urandom), 1'b1);
    end
    idle(4);
    tests_run++;
    if (got_q.size() !== exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_gap_count: got %0d pulses, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        tests_failed++;
        $display("FAIL rand_gap_out%0d: got %0d @%0d, expected %0d @%0d", i, $signed(got_q[i]), got_cyc_q[i], $signed(exp_q[i]), exp_cyc_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    for (int k = 0; k < 10 * R; k++) send(1'($urandom), 1'b1);
    idle(4);
    tests_run++;
    if (got_q.size() !== 7 || exp_q.size() !== 7) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d pulses, expected 7", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (got_q[i] !== exp_q[i] || got_cyc_q[i] !== exp_cyc_q[i]) begin
        tests_failed++;
        $display("FAIL b2b_out%0d: got %0d @%0d, expected %0d @%0d", i, $signed(got_q[i]), got_cyc_q[i], $signed(exp_q[i]), exp_cyc_q[i]);
      end
      if (i > 0) begin
        tests_run++;
        if (got_cyc_q[i] - got_cyc_q[i-1] !== R) begin
          tests_failed++;
          $display("FAIL b2b_spacing%0d: got %0d cycles, expected %0d", i, got_cyc_q[i] - got_cyc_q[i-1], R);
        end
      end
    end
  endtask

  task automatic test_modulator();
    int acc;
    int fb;
    bit b;
    int v;
    acc = 0;
    do_reset(1);
    // first-order modulator with constant input 8192 (full scale 32768)
    for (int k = 0; k < 8 * R; k++) begin
      b = (acc >= 0) ? 1'b0 : 1'b1;
      fb = b ? -32768 : 32768;
      acc += 8192 - fb;
      send(b, 1'b1);
    end
    idle(4);
    tests_run++;
    if (got_q.size() !== exp_q.size() || got_q.size() !== 5) begin
      tests_failed++;
      $display("FAIL mod_count: got %0d pulses, expected 5", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      v = int'($signed(got_q[i]));
      tests_run++;
      if (got_q[i] !== exp_q[i] || v < 8192 - 64 || v > 8192 + 64) begin
        tests_failed++;
        $display("FAIL mod_out%0d: got %0d, expected %0d (8192 +/-64)", i, v, $signed(exp_q[i]));
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(1);
    for (int k = 0; k < 4 * R + 40; k++) send(1'($urandom), 1'b1);
    tests_run++;
    if (got_q.size() !== 1 || exp_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL midrst_pre: got %0d pulses, expected 1 matching model", got_q.size());
    end
    rst_n = 1'b0;
    bus.valid_in = 1'b1;
    bus.din = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    clear_q();
    tests_run++;
    if (st !== WARMUP || bus.dout !== '0) begin
      tests_failed++;
      $display("FAIL midrst_after: got state %0d dout %0d, expected WARMUP 0", st, $signed(bus.dout));
    end
    for (int k = 0; k < R; k++) send(1'b0, 1'b1);
    tests_run++;
    if (bus.dout !== '0) begin tests_failed++; $display("FAIL midrst_hold0: got %0d, expected 0", $signed(bus.dout)); end
    for (int k = 0; k < 2 * R; k++) send(1'b0, 1'b1);
    idle(3);
    tests_run++;
    if (got_q.size() !== 0) begin tests_failed++; $display("FAIL midrst_quiet: got %0d pulses, expected 0", got_q.size()); end
    tests_run++;
    if (st !== RUN) begin tests_failed++; $display("FAIL midrst_run: got state %0d, expected RUN", st); end
    for (int k = 0; k < R; k++) send(1'b0, 1'b1);
    idle(4);
    tests_run++;
    if (got_q.size() !== 1 || exp_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL midrst_first: got %0d pulses, expected 1", got_q.size());
    end else if (got_q[0] !== 16'h7fff || got_cyc_q[0] !== exp_cyc_q[0]) begin
      tests_failed++;
      $display("FAIL midrst_first: got %0d @%0d, expected 32767 @%0d", $signed(got_q[0]), got_cyc_q[0], exp_cyc_q[0]);
    end
  endtask

  task automatic test_hold();
    tests_run++;
    if (hold_err !== 0) begin tests_failed++; $display("FAIL dout_hold: got %0d changes, expected 0", hold_err); end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.din = 1'b0;
    build_kernel();
    test_reset();
    test_const(1'b0, 4, 16'h7fff, "const0");
    test_const(1'b1, 6, 16'h8000, "const1");
    test_alternating();
    test_random_gaps();
    test_back_to_back();
    test_modulator();
    test_mid_reset();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sdm_demodulator.md
SDM_DEMODULATOR -- requirements
Module: sdm_demodulator

Interface
REQ-001 Parameter dac_bw, default 16, output PCM width in bits.
REQ-002 Parameter decim_log2, default 6, log2 of decimation ratio R (R = 64 at default).
REQ-003 Port clk  input  1  single clock, all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port valid_in  input  1  qualifies din for one cycle.
REQ-006 Port din  input  1  sigma-delta bitstream sample.
REQ-007 Port valid_out  output  1  one-cycle pulse marking a new dout word.
REQ-008 Port dout  output  dac_bw  signed two's-complement PCM sample.

Function
REQ-009 Bit mapping SHALL be: din=0 -> +1, din=1 -> -1, matching the modulator's feedback polarity.
REQ-010 Filter SHALL be 3rd-order CIC (sinc3), differential delay 1, internal width W = 3*decim_log2 + 2 (20 at default), wrap-around (modulo 2^W) arithmetic in all integrators and combs.
REQ-011 Three cascaded integrators SHALL update only on cycles with valid_in=1; valid_in=0 cycles SHALL leave all state unchanged.
REQ-012 A decimation counter SHALL count accepted samples 0..R-1 and wrap to 0; the accepted sample at count R-1 is the decimation tick.
REQ-013 On the tick cycle the last-integrator value including that sample SHALL be latched; the three comb stages SHALL evaluate on the following cycle.
REQ-014 Full-scale comb result is +/-R^3 (+/-262144 default); it SHALL be arithmetically right-shifted by (W - 1 - dac_bw) (3 default) and saturated to [-2^(dac_bw-1), 2^(dac_bw-1)-1].
REQ-015 Latency: valid_out SHALL assert exactly 2 cycles after the tick-cycle clock edge, for one cycle, with dout updated in that same cycle.
REQ-016 dout SHALL hold its value between valid_out pulses.
REQ-017 FSM states WARMUP and RUN: reset enters WARMUP; the first 3 comb outputs after reset are settling values -- dout updates but valid_out SHALL stay 0; 3rd completed output moves FSM to RUN; RUN persists until reset.
REQ-018 A tick arriving while the comb pipeline is still busy (only possible with R<2) is unsupported; decim_log2 SHALL be >= 1.
REQ-019 Back-to-back valid_in for the full stream SHALL sustain one output per R accepted samples with no loss.

Reset
REQ-020 When rst_n=0 at a clock edge: integrators, comb delays, decimation counter, warmup count cleared to 0; FSM to WARMUP; valid_out=0; dout=0.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame and any in-flight comb result; no valid_out in the cycle after reset release.
REQ-022 Reset SHALL take priority over valid_in on the same edge.

Structure
REQ-023 Shared package sdm_pkg SHALL hold CIC_ORDER=3, the state enum (WARMUP, RUN), and a function computing W from decim_log2.
REQ-024 One sub-module sdm_cic_stage SHALL implement a single integrator/comb pair pattern (enable-gated register of width W), instantiated three times.
REQ-025 Implementation target 120-400 lines of RTL, no vendor primitives.

Verification
REQ-026 Continuous valid_in, din=0 constant, 4 frames -> valid_out only after frame 3 completes, then dout=32767 (saturated from +32768).
REQ-027 Continuous valid_in, din=1 constant -> post-warmup dout=-32768 every frame, one pulse per 64 samples.
REQ-028 din alternating 0,1 -> post-warmup dout=0; 50% valid_in duty with random gaps -> identical dout sequence, pulse spacing ~128 cycles.
REQ-029 Drive output of matching sdm_modulator with constant PCM 8192 -> demodulated dout within +/-64 of +/-8192 (sign per REQ-009).
REQ-030 Assert rst_n=0 for 1 cycle at sample 40 of frame 5 -> no valid_out for the next 3 frames, FSM back in WARMUP, dout=0 until first settling output.
REQ-031 valid_in=1 with rst_n=0 on same edge -> counter stays 0, integrators stay 0.
